// File: rtl/vga_pkg.sv
// Shared timing defaults, display-mode encoding and colour-bar table for the VGA frame engine.
package vga_pkg;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_GAME   = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_WHITE  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_e;

    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // {R,G,B} full-scale enables, left-to-right bar order
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Single-clock VGA raster timing: pixel-enable divider, h/v counters, raw sync/active decode,
// end-of-visible-frame pulse and the frame-boundary shadow latch strobe.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW      = cnt_w(H_TOTAL),
    localparam int unsigned VW      = cnt_w(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_pix_ce,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output logic          o_active,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_end_frame,
    output logic          o_latch
);

    localparam int unsigned DW = cnt_w(CLK_DIV);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          w_pix_ce;
    logic          w_h_last;
    logic          w_v_last;
    logic [31:0]   w_h;
    logic [31:0]   w_v;

    assign w_pix_ce = (r_div == DW'(CLK_DIV - 1));
    assign w_h_last = (r_hcnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_vcnt == VW'(V_TOTAL - 1));
    assign w_h      = 32'(r_hcnt);
    assign w_v      = 32'(r_vcnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_div <= w_pix_ce ? '0 : r_div + DW'(1);
            if (w_pix_ce) begin
                if (w_h_last) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
                end else begin
                    r_hcnt <= r_hcnt + HW'(1);
                end
            end
        end
    end

    assign o_pix_ce    = w_pix_ce;
    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_active    = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign o_hs        = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign o_vs        = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    // Combinational so the pulse lines up with the qualifying pix_ce and lasts exactly one clk
    assign o_end_frame = !i_rst && w_pix_ce && w_h_last && (r_vcnt == VW'(V_ACTIVE - 1));
    assign o_latch     = w_pix_ce && w_h_last && w_v_last;

endmodule

// File: rtl/vga_frame_engine.sv
// Pong VGA output path: frame-synchronous position shadows, object hit tests, test-pattern colour mux
// and a 2-stage pixel pipeline keeping colour and sync aligned at the connector.
module vga_frame_engine
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned POS_W    = 10,
    parameter int unsigned PAD_W    = 10,
    parameter int unsigned PAD_H    = 60,
    parameter int unsigned PAD1_X   = 20,
    parameter int unsigned PAD2_X   = 610,
    parameter int unsigned BALL_SZ  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [POS_W-1:0]   y1,
    input  logic [POS_W-1:0]   y2,
    input  logic [POS_W-1:0]   xb,
    input  logic [POS_W-1:0]   yb,
    input  logic [1:0]         mode,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               end_frame
);

    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = cnt_w(H_TOTAL);
    localparam int unsigned VW      = cnt_w(V_TOTAL);
    localparam int unsigned EW      = max3(POS_W, HW, VW) + 1;
    localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic          w_pix_ce;
    logic [HW-1:0] w_hcnt;
    logic [VW-1:0] w_vcnt;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_latch;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_pix_ce    (w_pix_ce),
        .o_hcnt      (w_hcnt),
        .o_vcnt      (w_vcnt),
        .o_active    (w_active),
        .o_hs        (w_hs),
        .o_vs        (w_vs),
        .o_end_frame (end_frame),
        .o_latch     (w_latch)
    );

    logic [POS_W-1:0] r_y1;
    logic [POS_W-1:0] r_y2;
    logic [POS_W-1:0] r_xb;
    logic [POS_W-1:0] r_yb;
    mode_e            r_mode;

    // Shadows only move on the last pixel of the frame, so a whole frame sees one coherent set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y1   <= '0;
            r_y2   <= '0;
            r_xb   <= '0;
            r_yb   <= '0;
            r_mode <= MODE_GAME;
        end else if (w_latch) begin
            r_y1   <= y1;
            r_y2   <= y2;
            r_xb   <= xb;
            r_yb   <= yb;
            r_mode <= mode_e'(mode);
        end
    end

    logic [EW-1:0] w_x;
    logic [EW-1:0] w_y;
    logic          w_ball;
    logic          w_pad1;
    logic          w_pad2;
    logic          w_border;
    logic [2:0]    w_bar;

    // Widened compares: objects past the right/bottom edge clip instead of wrapping to 0
    assign w_x      = EW'(w_hcnt);
    assign w_y      = EW'(w_vcnt);
    assign w_ball   = (w_x >= EW'(r_xb)) && (w_x < EW'(r_xb) + EW'(BALL_SZ)) &&
                      (w_y >= EW'(r_yb)) && (w_y < EW'(r_yb) + EW'(BALL_SZ));
    assign w_pad1   = (w_x >= EW'(PAD1_X)) && (w_x < EW'(PAD1_X) + EW'(PAD_W)) &&
                      (w_y >= EW'(r_y1)) && (w_y < EW'(r_y1) + EW'(PAD_H));
    assign w_pad2   = (w_x >= EW'(PAD2_X)) && (w_x < EW'(PAD2_X) + EW'(PAD_W)) &&
                      (w_y >= EW'(r_y2)) && (w_y < EW'(r_y2) + EW'(PAD_H));
    assign w_border = (w_x == '0) || (w_x == EW'(H_ACTIVE - 1)) ||
                      (w_y == '0) || (w_y == EW'(V_ACTIVE - 1));
    assign w_bar    = (32'(w_hcnt) >= 7 * BAR_W) ? 3'd7 : 3'(32'(w_hcnt) / BAR_W);

    logic       r_s1_hit;
    logic       r_s1_border;
    logic [2:0] r_s1_bar;
    logic       r_s1_active;
    logic       r_s1_hs;
    logic       r_s1_vs;
    mode_e      r_s1_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hit    <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_bar    <= '0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_mode   <= MODE_GAME;
        end else if (w_pix_ce) begin
            r_s1_hit    <= w_ball || w_pad1 || w_pad2;
            r_s1_border <= w_border;
            r_s1_bar    <= w_bar;
            r_s1_active <= w_active;
            r_s1_hs     <= w_hs;
            r_s1_vs     <= w_vs;
            r_s1_mode   <= r_mode;
        end
    end

    logic [2:0] w_rgb;

    always_comb begin
        w_rgb = '0;
        if (r_s1_active) begin
            case (r_s1_mode)
                MODE_GAME:   w_rgb = {3{r_s1_hit}};
                MODE_BARS:   w_rgb = bar_rgb(r_s1_bar);
                MODE_WHITE:  w_rgb = 3'b111;
                MODE_BORDER: w_rgb = {3{r_s1_border}};
                default:     w_rgb = '0;
            endcase
        end
    end

    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_grn;
    logic [COLOR_W-1:0] r_blu;
    logic               r_hs;
    logic               r_vs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
        end else if (w_pix_ce) begin
            r_red <= {COLOR_W{w_rgb[2]}};
            r_grn <= {COLOR_W{w_rgb[1]}};
            r_blu <= {COLOR_W{w_rgb[0]}};
            r_hs  <= r_s1_hs ? HS_POL : ~HS_POL;
            r_vs  <= r_s1_vs ? VS_POL : ~VS_POL;
        end
    end

    assign vga_r  = r_red;
    assign vga_g  = r_grn;
    assign vga_b  = r_blu;
    assign vga_hs = r_hs;
    assign vga_vs = r_vs;

endmodule

// File: tb/tb_vga_frame_engine.sv
// Self-checking bench for vga_frame_engine on a shrunken raster, compared every clock against a
// pixel-index model of the display (frame shadows, hit rules, bars, border, sync windows, end_frame).
module tb_vga_frame_engine;

    localparam int D   = 2;
    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int F   = HT * VT;
    localparam int PW  = 2;
    localparam int PH  = 6;
    localparam int P1X = 4;
    localparam int P2X = 58;
    localparam int BS  = 4;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] y1 = '0;
    logic [9:0] y2 = '0;
    logic [9:0] xb = '0;
    logic [9:0] yb = '0;
    logic [1:0] mode = '0;
    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       end_frame;

    int n_asserts = 0;
    int n_fail    = 0;
    int n         = -1;
    int sh_y1 [16];
    int sh_y2 [16];
    int sh_xb [16];
    int sh_yb [16];
    int sh_md [16];
    logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    vga_frame_engine #(
        .CLK_DIV  (D),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HSY),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP),
        .HS_POL   (HSP),
        .VS_POL   (VSP),
        .COLOR_W  (4),
        .POS_W    (10),
        .PAD_W    (PW),
        .PAD_H    (PH),
        .PAD1_X   (P1X),
        .PAD2_X   (P2X),
        .BALL_SZ  (BS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .y1        (y1),
        .y2        (y2),
        .xb        (xb),
        .yb        (yb),
        .mode      (mode),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .end_frame (end_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (clk %0d after reset release)", tag, obs, exp, n);
        end
    endtask

    // Expected pins for linear pixel index p counted from the first pixel after reset
    task automatic expect_pixel(input int p, output logic [11:0] rgb, output logic hs, output logic vs);
        int fi, pos, h, v;
        logic [2:0] on;
        logic hit;
        fi  = p / F;
        if (fi > 15) fi = 15;
        pos = p % F;
        h   = pos % HT;
        v   = pos / HT;
        on  = 3'b000;
        if (h < HA && v < VA) begin
            case (sh_md[fi])
                0: begin
                    hit = (h >= sh_xb[fi] && h < sh_xb[fi] + BS && v >= sh_yb[fi] && v < sh_yb[fi] + BS) ||
                          (h >= P1X && h < P1X + PW && v >= sh_y1[fi] && v < sh_y1[fi] + PH) ||
                          (h >= P2X && h < P2X + PW && v >= sh_y2[fi] && v < sh_y2[fi] + PH);
                    on = hit ? 3'b111 : 3'b000;
                end
                1: on = bar_tab[h / (HA / 8)];
                2: on = 3'b111;
                default: on = (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? 3'b111 : 3'b000;
            endcase
        end
        rgb = {{4{on[2]}}, {4{on[1]}}, {4{on[0]}}};
        hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
        vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
    endtask

    task automatic check_outputs();
        logic [11:0] er;
        logic eh, ev, ee;
        int m;
        er = '0;
        eh = ~HSP;
        ev = ~VSP;
        ee = 1'b0;
        if (n >= 0) begin
            m = (n + 1) / D;
            if (m >= 2) expect_pixel(m - 2, er, eh, ev);
            ee = ((n + 2) % D == 0) && (m % F == (VA - 1) * HT + HT - 1);
        end
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(er));
        check("hs", 32'(vga_hs), 32'(eh));
        check("vs", 32'(vga_vs), 32'(ev));
        check("end_frame", 32'(end_frame), 32'(ee));
    endtask

    task automatic tick();
        int m, fi;
        @(posedge clk);
        if (rst) begin
            n = -1;
            sh_y1[0] = 0; sh_y2[0] = 0; sh_xb[0] = 0; sh_yb[0] = 0; sh_md[0] = 0;
        end else begin
            n++;
            m = (n + 1) / D;
            if ((n + 1) % D == 0 && m % F == 0) begin
                fi = m / F;
                if (fi < 16) begin
                    sh_y1[fi] = int'(y1); sh_y2[fi] = int'(y2);
                    sh_xb[fi] = int'(xb); sh_yb[fi] = int'(yb);
                    sh_md[fi] = int'(mode);
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [9:0] rand_pos();
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(1000, 1023));
        return 10'($urandom_range(0, 85));
    endfunction

    initial begin
        rst = 1'b1;
        repeat (4) tick();

        rst  = 1'b0;
        mode = 2'd0;
        xb   = 10'd10;
        yb   = 10'd20;
        y1   = 10'd5;
        y2   = 10'd30;
        repeat (2 * F * D + 50) tick();

        // Positions wander mid-frame; mode steps through all four patterns
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < F * D; c++) begin
                tick();
                if ($urandom_range(0, 149) == 0) begin
                    y1 = rand_pos();
                    y2 = rand_pos();
                    xb = rand_pos();
                    yb = rand_pos();
                end
                if (c == F * D / 2) mode = 2'(f);
            end
        end

        xb   = 10'd1020;
        yb   = 10'd2;
        mode = 2'd0;
        repeat (1234) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (F * D + F * D / 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
